// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-side ids/enables in, stall/flush/forward controls out
interface hazard_control_unit_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 16);
  logic [REG_ADDR_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic BranchD, syscallD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD, syscall_fire;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output BranchD, syscallD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
    input StallF, StallD, FlushE, ForwardAD, ForwardBD, syscall_fire, ForwardAE, ForwardBE, stall_cycles
  );
  modport slave (
    input RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input BranchD, syscallD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, syscall_fire, ForwardAE, ForwardBE, stall_cycles
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: MIPS hazard/forwarding control with syscall drain FSM and saturating stall counter
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN = 1,
  parameter int BRANCH_IN_DECODE = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset_n,
  hazard_control_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, FIRE, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic mse, mte, msm, mtm, msw, mtw, lwstall, brstall, rawstall, hstall;
  function automatic logic match(input logic [REG_ADDR_W-1:0] x, input logic [REG_ADDR_W-1:0] id, input logic we);
    return we && id != '0 && id == x;
  endfunction
  assign mse = match(bus.RsD, bus.WriteRegE, bus.RegWriteE);
  assign mte = match(bus.RtD, bus.WriteRegE, bus.RegWriteE);
  assign msm = match(bus.RsD, bus.WriteRegM, bus.RegWriteM);
  assign mtm = match(bus.RtD, bus.WriteRegM, bus.RegWriteM);
  assign msw = match(bus.RsD, bus.WriteRegW, bus.RegWriteW);
  assign mtw = match(bus.RtD, bus.WriteRegW, bus.RegWriteW);
  assign lwstall = bus.MemtoRegE && (mse || mte);
  // a load in M cannot feed the decode comparator yet, whatever RegWriteM says
  assign brstall = BRANCH_IN_DECODE != 0 && bus.BranchD && (mse || mte ||
    (bus.MemtoRegM && (match(bus.RsD, bus.WriteRegM, 1'b1) || match(bus.RtD, bus.WriteRegM, 1'b1))));
  assign rawstall = FWD_EN == 0 && (mse || mte || msm || mtm || msw || mtw);
  assign hstall = lwstall || brstall || rawstall;
  assign bus.ForwardAE = FWD_EN == 0 ? 2'b00 :
    match(bus.RsE, bus.WriteRegM, bus.RegWriteM) ? 2'b10 :
    match(bus.RsE, bus.WriteRegW, bus.RegWriteW) ? 2'b01 : 2'b00;
  assign bus.ForwardBE = FWD_EN == 0 ? 2'b00 :
    match(bus.RtE, bus.WriteRegM, bus.RegWriteM) ? 2'b10 :
    match(bus.RtE, bus.WriteRegW, bus.RegWriteW) ? 2'b01 : 2'b00;
  assign bus.ForwardAD = BRANCH_IN_DECODE != 0 && msm;
  assign bus.ForwardBD = BRANCH_IN_DECODE != 0 && mtm;
  assign bus.StallF = state == IDLE ? hstall : state != DONE;
  assign bus.StallD = bus.StallF;
  assign bus.FlushE = state == IDLE ? hstall : 1'b1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.syscall_fire <= 1'b0;
    end else begin
      bus.syscall_fire <= 1'b0;
      case (state)
        IDLE: if (bus.syscallD && !hstall) begin
          state <= DRAIN;
          cnt <= 4'(DRAIN_CYCLES - 1);
        end
        DRAIN: if (cnt == '0) begin
          state <= FIRE;
          bus.syscall_fire <= 1'b1;
        end else cnt <= cnt - 4'd1;
        FIRE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) bus.stall_cycles <= '0;
    else if (bus.StallF && bus.stall_cycles != '1) bus.stall_cycles <= bus.stall_cycles + 1'b1;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: random + directed stimulus on a forwarding and a non-forwarding instance vs a reference model
module tb_hazard_control_unit;
  localparam int DC = 3;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic BranchD, syscallD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  int checks = 0, errors = 0;
  int rem[2] = '{0, 0};
  int cnt[2] = '{0, 0};
  int cmax[2] = '{65535, 15};
  hazard_control_unit_if hif0 ();
  hazard_control_unit_if #(.CNT_W(4)) hif1 ();
  hazard_control_unit #(.DRAIN_CYCLES(DC)) dut0 (.clock(clock), .reset_n(reset_n), .bus(hif0.slave));
  hazard_control_unit #(.FWD_EN(0), .DRAIN_CYCLES(DC), .CNT_W(4)) dut1 (.clock(clock), .reset_n(reset_n), .bus(hif1.slave));
  assign hif0.RsD = RsD, hif0.RtD = RtD, hif0.RsE = RsE, hif0.RtE = RtE, hif0.WriteRegE = WriteRegE,
    hif0.WriteRegM = WriteRegM, hif0.WriteRegW = WriteRegW, hif0.BranchD = BranchD, hif0.syscallD = syscallD,
    hif0.RegWriteE = RegWriteE, hif0.MemtoRegE = MemtoRegE, hif0.RegWriteM = RegWriteM,
    hif0.MemtoRegM = MemtoRegM, hif0.RegWriteW = RegWriteW;
  assign hif1.RsD = RsD, hif1.RtD = RtD, hif1.RsE = RsE, hif1.RtE = RtE, hif1.WriteRegE = WriteRegE,
    hif1.WriteRegM = WriteRegM, hif1.WriteRegW = WriteRegW, hif1.BranchD = BranchD, hif1.syscallD = syscallD,
    hif1.RegWriteE = RegWriteE, hif1.MemtoRegE = MemtoRegE, hif1.RegWriteM = RegWriteM,
    hif1.MemtoRegM = MemtoRegM, hif1.RegWriteW = RegWriteW;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m(input logic [4:0] x, input logic [4:0] id, input logic we);
    return we && id != 0 && id == x;
  endfunction
  function automatic bit hz(input bit fwd);
    logic [4:0] src[2];
    bit h = 0;
    src[0] = RsD;
    src[1] = RtD;
    foreach (src[i]) begin
      h |= MemtoRegE && m(src[i], WriteRegE, RegWriteE);
      h |= BranchD && (m(src[i], WriteRegE, RegWriteE) || (MemtoRegM && m(src[i], WriteRegM, 1'b1)));
      h |= !fwd && (m(src[i], WriteRegE, RegWriteE) || m(src[i], WriteRegM, RegWriteM) || m(src[i], WriteRegW, RegWriteW));
    end
    return h;
  endfunction
  function automatic int fwd_sel(input bit fwd, input logic [4:0] r);
    return !fwd ? 0 : m(r, WriteRegM, RegWriteM) ? 2 : m(r, WriteRegW, RegWriteW) ? 1 : 0;
  endfunction
  task automatic check_one(input int k, input logic sf, input logic sd, input logic fe, input logic fire,
                           input logic [1:0] fae, input logic [1:0] fbe, input logic fad, input logic fbd, input int sc);
    bit fwd = (k == 0);
    bit hs = hz(fwd);
    bit busy = rem[k] > 0;
    bit es = busy ? rem[k] >= 2 : hs;
    bit ef = busy ? 1'b1 : hs;
    chk($sformatf("StallF%0d", k), sf, es);
    chk($sformatf("StallD%0d", k), sd, es);
    chk($sformatf("FlushE%0d", k), fe, ef);
    chk($sformatf("fire%0d", k), fire, rem[k] == 2);
    chk($sformatf("ForwardAE%0d", k), fae, fwd_sel(fwd, RsE));
    chk($sformatf("ForwardBE%0d", k), fbe, fwd_sel(fwd, RtE));
    chk($sformatf("ForwardAD%0d", k), fad, m(RsD, WriteRegM, RegWriteM));
    chk($sformatf("ForwardBD%0d", k), fbd, m(RtD, WriteRegM, RegWriteM));
    chk($sformatf("stall_cycles%0d", k), sc, cnt[k]);
    if (es && cnt[k] < cmax[k]) cnt[k]++;
    if (busy) rem[k]--;
    else if (syscallD && !hs) rem[k] = DC + 2;
  endtask
  task automatic cycle();
    #1;
    check_one(0, hif0.StallF, hif0.StallD, hif0.FlushE, hif0.syscall_fire, hif0.ForwardAE, hif0.ForwardBE,
              hif0.ForwardAD, hif0.ForwardBD, int'(hif0.stall_cycles));
    check_one(1, hif1.StallF, hif1.StallD, hif1.FlushE, hif1.syscall_fire, hif1.ForwardAE, hif1.ForwardBE,
              hif1.ForwardAD, hif1.ForwardBD, int'(hif1.stall_cycles));
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic clear();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {BranchD, syscallD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW} = '0;
  endtask
  initial begin
    clear();
    #12;
    chk("rst_cnt0", int'(hif0.stall_cycles), 0);
    chk("rst_cnt1", int'(hif1.stall_cycles), 0);
    chk("rst_fire0", hif0.syscall_fire, 0);
    @(negedge clock);
    reset_n = 1'b1;
    RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
    cycle();
    RegWriteM = 0;
    cycle();
    RegWriteM = 1; WriteRegM = 0; RegWriteW = 0;
    cycle();
    clear(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    cycle();
    clear(); BranchD = 1; RsD = 4; WriteRegE = 4; RegWriteE = 1;
    cycle();
    clear(); BranchD = 1; RsD = 4; WriteRegM = 4; RegWriteM = 1;
    cycle();
    clear(); syscallD = 1;
    for (int i = 0; i < DC + 4; i++) cycle();
    for (int i = 0; i < 600; i++) begin
      {RsD, RtD, RsE, RtE} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      {WriteRegE, WriteRegM, WriteRegW} = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = 5'($urandom);
      BranchD = $urandom_range(0, 3) == 0;
      syscallD = $urandom_range(0, 4) == 0;
      cycle();
    end
    clear();
    for (int i = 0; i < 20 && (rem[0] != 0 || rem[1] != 0); i++) cycle();
    chk("drained0", rem[0], 0);
    syscallD = 1;
    cycle();
    cycle();
    reset_n = 1'b0;
    #1;
    rem = '{0, 0};
    cnt = '{0, 0};
    chk("mid_rst_cnt0", int'(hif0.stall_cycles), 0);
    chk("mid_rst_fire0", hif0.syscall_fire, 0);
    chk("mid_rst_StallF0", hif0.StallF, 0);
    chk("mid_rst_FlushE1", hif1.FlushE, 0);
    syscallD = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < DC + 3; i++) cycle();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    for (int i = 0; i < 20; i++) cycle();
    #1;
    chk("sat1", int'(hif1.stall_cycles), 15);
    chk("cnt20_0", int'(hif0.stall_cycles), 20);
    clear(); RsD = 5; WriteRegW = 5; RegWriteW = 1;
    #1;
    chk("raw_StallD1", hif1.StallD, 1);
    chk("raw_StallD0", hif0.StallD, 0);
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
